// File: rtl/bnn_wx_mem_responder.sv
// ---------------------------------------------------------------------------
// bnn_wx_mem_responder
//   Memory-side responder for the BNN compute engine's weight (W) and
//   activation (X) request ports. Each port reads with a registered one-cycle
//   latency (read-first against a same-edge write) and accepts 1-bit
//   write-backs from wx_write. A preload port fills either memory before
//   compute and wins over a requester write to the same memory on the same
//   edge. Sticky error flags and saturating access counters support checking.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wx_write                  write data for any requester write
//   w_addr/w_sel/w_rq/w_wq    W request port; w_data registered read data
//   x_addr/x_sel/x_rq/x_wq    X request port; x_data registered read data
//   ld_en/ld_tgt/ld_sel/      preload strobe, target (0 = W, 1 = X), bank,
//   ld_addr/ld_data           address and data (low bits used for X)
//   range_err                 sticky: any access with addr >= depth
//   collide_err               sticky: requester write dropped by a preload
//   rd_cnt/wr_cnt             saturating counts of accepted reads / writes
// ---------------------------------------------------------------------------
module bnn_wx_mem_responder #(
  parameter int unsigned W_ADDR_LEN = 20,
  parameter int unsigned W_DATA_LEN = 1,
  parameter int unsigned W_SEL_LEN  = 2,
  parameter int unsigned W_DEPTH    = 802816,
  parameter int unsigned X_ADDR_LEN = 10,
  parameter int unsigned X_DATA_LEN = 1,
  parameter int unsigned X_SEL_LEN  = 2,
  parameter int unsigned X_DEPTH    = 1024,
  parameter int unsigned CNT_LEN    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wx_write,
  input  logic [W_ADDR_LEN-1:0] w_addr,
  input  logic [W_SEL_LEN-1:0]  w_sel,
  input  logic                  w_rq,
  input  logic                  w_wq,
  output logic [W_DATA_LEN-1:0] w_data,
  input  logic [X_ADDR_LEN-1:0] x_addr,
  input  logic [X_SEL_LEN-1:0]  x_sel,
  input  logic                  x_rq,
  input  logic                  x_wq,
  output logic [X_DATA_LEN-1:0] x_data,
  input  logic                  ld_en,
  input  logic                  ld_tgt,
  input  logic [W_SEL_LEN-1:0]  ld_sel,
  input  logic [W_ADDR_LEN-1:0] ld_addr,
  input  logic                  ld_data,
  output logic                  range_err,
  output logic                  collide_err,
  output logic [CNT_LEN-1:0]    rd_cnt,
  output logic [CNT_LEN-1:0]    wr_cnt
);

  localparam int unsigned W_BANKS = 2 ** W_SEL_LEN;
  localparam int unsigned X_BANKS = 2 ** X_SEL_LEN;

  logic [W_DATA_LEN-1:0] w_mem [W_BANKS][W_DEPTH];
  logic [X_DATA_LEN-1:0] x_mem [X_BANKS][X_DEPTH];

  // X preload uses the low bits of the shared preload bank/address fields.
  logic [X_SEL_LEN-1:0]  ld_x_sel;
  logic [X_ADDR_LEN-1:0] ld_x_addr;
  assign ld_x_sel  = ld_sel[X_SEL_LEN-1:0];
  assign ld_x_addr = ld_addr[X_ADDR_LEN-1:0];

  logic w_in, x_in, ld_w_in, ld_x_in;
  logic w_ld, x_ld;
  logic w_rd_ok, x_rd_ok, w_wr_ok, x_wr_ok;
  logic range_hit, collide_hit;
  logic [1:0] rd_inc, wr_inc;

  // NOTE: every signal driven here gets its value on every path (plain
  // continuous expressions, defaults first) so no latch can be inferred.
  always_comb begin
    w_in    = 32'(w_addr)    < W_DEPTH;
    x_in    = 32'(x_addr)    < X_DEPTH;
    ld_w_in = 32'(ld_addr)   < W_DEPTH;
    ld_x_in = 32'(ld_x_addr) < X_DEPTH;

    w_ld = ld_en && !ld_tgt;
    x_ld = ld_en &&  ld_tgt;

    // A preload to a memory blocks requester writes to that whole memory,
    // regardless of address.
    w_rd_ok = w_rq && w_in;
    x_rd_ok = x_rq && x_in;
    w_wr_ok = w_wq && w_in && !w_ld;
    x_wr_ok = x_wq && x_in && !x_ld;

    range_hit = ((w_rq || w_wq) && !w_in) ||
                ((x_rq || x_wq) && !x_in) ||
                (w_ld && !ld_w_in) ||
                (x_ld && !ld_x_in);
    collide_hit = (w_wq && w_ld) || (x_wq && x_ld);

    rd_inc = {1'b0, w_rd_ok} + {1'b0, x_rd_ok};
    wr_inc = {1'b0, w_wr_ok} + {1'b0, x_wr_ok};
  end

  function automatic logic [CNT_LEN-1:0] sat_add(input logic [CNT_LEN-1:0] c,
                                                 input logic [1:0]         inc);
    logic [CNT_LEN:0] s;
    s = {1'b0, c} + (CNT_LEN+1)'(inc);
    return s[CNT_LEN] ? '1 : s[CNT_LEN-1:0];
  endfunction

  // NOTE: the memory arrays have no reset branch on purpose; contents must
  // survive rst, and a reset would turn the arrays into a sea of flops.
  always_ff @(posedge clk) begin
    if (w_ld && ld_w_in)
      w_mem[ld_sel][ld_addr] <= {W_DATA_LEN{ld_data}};
    else if (w_wr_ok)
      w_mem[w_sel][w_addr] <= {W_DATA_LEN{wx_write}};

    if (x_ld && ld_x_in)
      x_mem[ld_x_sel][ld_x_addr] <= {X_DATA_LEN{ld_data}};
    else if (x_wr_ok)
      x_mem[x_sel][x_addr] <= {X_DATA_LEN{wx_write}};
  end

  // NOTE: non-blocking assignments make the reads below sample the pre-edge
  // memory contents, which is exactly the read-first behaviour required.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_data      <= '0;
      x_data      <= '0;
      range_err   <= 1'b0;
      collide_err <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else begin
      if (w_rq) w_data <= w_in ? w_mem[w_sel][w_addr] : '0;
      if (x_rq) x_data <= x_in ? x_mem[x_sel][x_addr] : '0;
      if (range_hit)   range_err   <= 1'b1;
      if (collide_hit) collide_err <= 1'b1;
      rd_cnt <= sat_add(rd_cnt, rd_inc);
      wr_cnt <= sat_add(wr_cnt, wr_inc);
    end
  end

endmodule

// File: tb/tb_bnn_wx_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bnn_wx_mem_responder
//   Directed bench for bnn_wx_mem_responder. Expected read data is pushed to
//   a scoreboard queue when a read is issued and compared one edge later.
//   A second instance with a 4-bit counter covers counter saturation.
// ---------------------------------------------------------------------------
module tb_bnn_wx_mem_responder;

  localparam int W_DEPTH = 802816;

  logic        clk = 1'b0;
  logic        rst;
  logic        wx_write;
  logic [19:0] w_addr;
  logic [1:0]  w_sel;
  logic        w_rq, w_wq;
  logic [0:0]  w_data;
  logic [9:0]  x_addr;
  logic [1:0]  x_sel;
  logic        x_rq, x_wq;
  logic [0:0]  x_data;
  logic        ld_en, ld_tgt;
  logic [1:0]  ld_sel;
  logic [19:0] ld_addr;
  logic        ld_data;
  logic        range_err, collide_err;
  logic [31:0] rd_cnt, wr_cnt;

  // saturation instance signals
  logic        s_rq, s_wq;
  logic [0:0]  s_w_data, s_x_data;
  logic        s_range_err, s_collide_err;
  logic [3:0]  s_rd_cnt, s_wr_cnt;

  always #5 clk = ~clk;

  bnn_wx_mem_responder u_dut (
    .clk(clk), .rst(rst), .wx_write(wx_write),
    .w_addr(w_addr), .w_sel(w_sel), .w_rq(w_rq), .w_wq(w_wq), .w_data(w_data),
    .x_addr(x_addr), .x_sel(x_sel), .x_rq(x_rq), .x_wq(x_wq), .x_data(x_data),
    .ld_en(ld_en), .ld_tgt(ld_tgt), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .range_err(range_err), .collide_err(collide_err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  bnn_wx_mem_responder #(.W_DEPTH(64), .CNT_LEN(4)) u_sat (
    .clk(clk), .rst(rst), .wx_write(1'b1),
    .w_addr(20'd3), .w_sel(2'd0), .w_rq(s_rq), .w_wq(s_wq), .w_data(s_w_data),
    .x_addr(10'd3), .x_sel(2'd0), .x_rq(s_rq), .x_wq(s_wq), .x_data(s_x_data),
    .ld_en(1'b0), .ld_tgt(1'b0), .ld_sel(2'd0), .ld_addr(20'd0),
    .ld_data(1'b0), .range_err(s_range_err), .collide_err(s_collide_err),
    .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt)
  );

  typedef struct {
    string name;
    bit    is_x;
    logic  val;
  } exp_t;

  exp_t sb[$];
  logic xm [4][1024];
  logic wm [int];
  int   tests = 0;
  int   fails = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock edge, then settle and drain the scoreboard (read latency = 1).
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, e.is_x ? 32'(x_data) : 32'(w_data), 32'(e.val));
    end
  endtask

  task automatic exp_x(input string n, input int sel, input int addr);
    sb.push_back('{n, 1'b1, xm[sel][addr]});
    exp_rd++;
  endtask

  task automatic exp_w(input string n, input int sel, input int addr);
    sb.push_back('{n, 1'b0, wm[sel*W_DEPTH+addr]});
    exp_rd++;
  endtask

  task automatic preload(input bit tgt, input int sel, input int addr, input logic d);
    ld_en = 1'b1; ld_tgt = tgt; ld_sel = 2'(sel); ld_addr = 20'(addr); ld_data = d;
    tick();
    ld_en = 1'b0;
    if (tgt) xm[sel][addr] = d;
    else     wm[sel*W_DEPTH+addr] = d;
  endtask

  task automatic x_read(input string n, input int sel, input int addr);
    x_rq = 1'b1; x_sel = 2'(sel); x_addr = 10'(addr);
    exp_x(n, sel, addr);
    tick();
    x_rq = 1'b0;
  endtask

  task automatic check_cnts(input string n);
    check({n, "_rd_cnt"}, rd_cnt, 32'(exp_rd));
    check({n, "_wr_cnt"}, wr_cnt, 32'(exp_wr));
  endtask

  logic [3:0] pat;

  initial begin
    rst = 1'b1; wx_write = 1'b0;
    w_addr = '0; w_sel = '0; w_rq = 1'b0; w_wq = 1'b0;
    x_addr = '0; x_sel = '0; x_rq = 1'b0; x_wq = 1'b0;
    ld_en = 1'b0; ld_tgt = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = 1'b0;
    s_rq = 1'b0; s_wq = 1'b0;

    // Reset state
    #12;
    check("rst_w_data", 32'(w_data), 0);
    check("rst_x_data", 32'(x_data), 0);
    check("rst_range_err", 32'(range_err), 0);
    check("rst_collide_err", 32'(collide_err), 0);
    check_cnts("rst");
    rst = 1'b0;

    // 1: preload X bank0, then back-to-back reads one word per cycle
    pat = 4'b1101;  // addr0..3 = 1,0,1,1
    for (int i = 0; i < 4; i++) preload(1'b1, 0, i, pat[i]);
    preload(1'b1, 0, 5, 1'b0);
    check_cnts("preload_uncounted");
    x_rq = 1'b1; x_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      x_addr = 10'(i);
      exp_x($sformatf("x_burst_%0d", i), 0, i);
      tick();
    end
    x_rq = 1'b0;
    check_cnts("burst");
    x_addr = 10'd1;  // rq low: data must hold the last value (1)
    tick();
    check("x_hold", 32'(x_data), 1);

    // W preloads at the depth boundary and bank 3, read back-to-back
    preload(1'b0, 2, W_DEPTH-1, 1'b1);
    preload(1'b0, 3, 0, 1'b1);
    w_rq = 1'b1; w_sel = 2'd2; w_addr = 20'(W_DEPTH-1);
    exp_w("w_last_word", 2, W_DEPTH-1);
    tick();
    w_sel = 2'd3; w_addr = 20'd0;
    exp_w("w_bank3_0", 3, 0);
    tick();
    w_rq = 1'b0;
    check("no_range_err_yet", 32'(range_err), 0);

    // 2: requester write to bank1, read back; bank0 untouched
    x_wq = 1'b1; x_sel = 2'd1; x_addr = 10'd5; wx_write = 1'b1;
    tick();
    x_wq = 1'b0; xm[1][5] = 1'b1; exp_wr++;
    x_read("x_wr_readback", 1, 5);
    x_read("x_bank0_unchanged", 0, 5);
    check_cnts("write");

    // 3: read-first on a same-edge read + write
    preload(1'b1, 1, 7, 1'b0);
    x_rq = 1'b1; x_wq = 1'b1; x_sel = 2'd1; x_addr = 10'd7; wx_write = 1'b1;
    exp_x("x_read_first_old", 1, 7);
    tick();
    x_rq = 1'b0; x_wq = 1'b0; xm[1][7] = 1'b1; exp_wr++;
    x_read("x_read_first_new", 1, 7);
    check_cnts("rmw");

    // Both ports read on one edge (+2)
    w_rq = 1'b1; w_sel = 2'd2; w_addr = 20'(W_DEPTH-1);
    x_rq = 1'b1; x_sel = 2'd0; x_addr = 10'd0;
    exp_w("dual_w", 2, W_DEPTH-1);
    exp_x("dual_x", 0, 0);
    tick();
    w_rq = 1'b0; x_rq = 1'b0;
    check_cnts("dual");

    // 4: out-of-range W read -> 0, range_err, not counted
    w_rq = 1'b1; w_sel = 2'd0; w_addr = 20'(W_DEPTH);
    sb.push_back('{"w_oor_zero", 1'b0, 1'b0});
    tick();
    w_rq = 1'b0;
    check("range_err_set", 32'(range_err), 1);
    check_cnts("oor");

    // Collision: requester write dropped, preload at a different addr stored
    preload(1'b1, 2, 9, 1'b1);
    check("collide_clear", 32'(collide_err), 0);
    x_wq = 1'b1; x_sel = 2'd2; x_addr = 10'd9; wx_write = 1'b0;
    ld_en = 1'b1; ld_tgt = 1'b1; ld_sel = 2'd2; ld_addr = 20'd10; ld_data = 1'b1;
    tick();
    x_wq = 1'b0; ld_en = 1'b0; xm[2][10] = 1'b1;
    check("collide_err_set", 32'(collide_err), 1);
    x_read("x_dropped_write", 2, 9);
    x_read("x_collide_preload", 2, 10);

    // Read during a same-address preload returns the pre-edge value
    x_rq = 1'b1; x_sel = 2'd0; x_addr = 10'd1;
    ld_en = 1'b1; ld_tgt = 1'b1; ld_sel = 2'd0; ld_addr = 20'd1; ld_data = 1'b1;
    exp_x("x_preload_read_old", 0, 1);
    tick();
    x_rq = 1'b0; ld_en = 1'b0; xm[0][1] = 1'b1;
    x_read("x_preload_read_new", 0, 1);

    // W requester write to bank3 addr0, read back
    w_wq = 1'b1; w_sel = 2'd3; w_addr = 20'd0; wx_write = 1'b0;
    tick();
    w_wq = 1'b0; wm[3*W_DEPTH] = 1'b0; exp_wr++;
    w_rq = 1'b1;
    exp_w("w_wr_readback", 3, 0);
    tick();
    w_rq = 1'b0;
    check_cnts("pre_reset");
    check("flags_sticky", {30'd0, range_err, collide_err}, 32'd3);

    // 5: async reset between two reads; contents survive
    x_read("x_before_rst", 0, 0);
    x_rq = 1'b1; x_addr = 10'd1;
    #1 rst = 1'b1;
    #1;
    check("async_x_data", 32'(x_data), 0);
    check("async_w_data", 32'(w_data), 0);
    check("async_flags", {30'd0, range_err, collide_err}, 0);
    exp_rd = 0; exp_wr = 0;
    check_cnts("async");
    tick();
    x_rq = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) x_read($sformatf("x_after_rst_%0d", i), 0, i);
    check_cnts("after_rst");

    // 6: 4-bit counters saturate at 15 (two reads + two writes per edge)
    s_rq = 1'b1; s_wq = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("sat_rd_14", 32'(s_rd_cnt), 14);
    tick();
    check("sat_rd_15", 32'(s_rd_cnt), 15);
    for (int i = 0; i < 12; i++) tick();
    s_rq = 1'b0; s_wq = 1'b0;
    check("sat_rd_hold", 32'(s_rd_cnt), 15);
    check("sat_wr_hold", 32'(s_wr_cnt), 15);
    check("sat_no_errs", {30'd0, s_range_err, s_collide_err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
